// File: rtl/memory_access_arbiter_pkg.sv
// Shared encodings and defaults for the weight/state memory arbiter.
// Holds the FSM state and owner codes plus the tie-break helper.
package snn_mem_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  localparam int unsigned ST_WIDTH = 2;
  typedef logic [ST_WIDTH-1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  typedef logic owner_t;

  localparam owner_t OWN_SPI  = 1'b0;
  localparam owner_t OWN_CORE = 1'b1;

  // Winner among the live candidates; on a tie the previous loser goes first.
  function automatic owner_t pick_owner(input logic   spi_cand,
                                        input logic   core_cand,
                                        input owner_t last_winner);
    owner_t win;
    if (spi_cand && core_cand) begin
      win = (last_winner == OWN_CORE) ? OWN_SPI : OWN_CORE;
    end else if (spi_cand) begin
      win = OWN_SPI;
    end else begin
      win = OWN_CORE;
    end
    return win;
  endfunction

endpackage

// File: rtl/memory_access_arbiter_if.sv
// Bus bundle between the arbiter, the SPI front end, the neuron core and the memory.
// slave is the arbiter's view; master is the view of everything around it.
interface memory_access_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = snn_mem_pkg::DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = snn_mem_pkg::DEFAULT_DATA_WIDTH
);

  logic                  spi_req;
  logic                  spi_we;
  logic [ADDR_WIDTH-1:0] spi_addr;
  logic [DATA_WIDTH-1:0] spi_wdata;
  logic                  spi_done;
  logic [DATA_WIDTH-1:0] spi_rdata;
  logic                  spi_overrun;

  logic                  core_req;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic                  core_done;
  logic [DATA_WIDTH-1:0] core_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  spi_req, spi_we, spi_addr, spi_wdata,
    output spi_done, spi_rdata, spi_overrun,
    input  core_req, core_addr,
    output core_done, core_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output spi_req, spi_we, spi_addr, spi_wdata,
    input  spi_done, spi_rdata, spi_overrun,
    output core_req, core_addr,
    input  core_done, core_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/memory_access_arbiter_spi_buf.sv
// One-deep holding register for unstallable SPI request pulses.
// A pulse landing on a full, ungranted buffer is dropped and flagged sticky.
module spi_req_buffer #(
  parameter int unsigned ADDR_WIDTH = snn_mem_pkg::DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = snn_mem_pkg::DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_req,
  input  logic                  spi_we,
  input  logic [ADDR_WIDTH-1:0] spi_addr,
  input  logic [DATA_WIDTH-1:0] spi_wdata,
  input  logic                  grant,
  output logic                  pend_valid,
  output logic                  pend_we,
  output logic [ADDR_WIDTH-1:0] pend_addr,
  output logic [DATA_WIDTH-1:0] pend_wdata,
  output logic                  overrun
);

  logic accept_c;
  logic drop_c;

  // The slot frees on the granting edge, so a pulse on that edge still fits.
  assign accept_c = spi_req && (grant || !pend_valid);
  assign drop_c   = spi_req && pend_valid && !grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      overrun    <= 1'b0;
    end else begin
      if (accept_c) begin
        pend_valid <= 1'b1;
        pend_we    <= spi_we;
        pend_addr  <= spi_addr;
        pend_wdata <= spi_wdata;
      end else if (grant) begin
        pend_valid <= 1'b0;
      end
      if (drop_c) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_access_arbiter.sv
// Arbitrates the single-port weight/state memory between SPI and the neuron core.
// Each grant runs one IDLE->ACCESS->RESP slot with a single registered memory strobe.
module memory_access_arbiter
  import snn_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  memory_access_arbiter_if.slave bus
);

  state_t state_q;
  state_t state_d;

  logic                  pend_valid;
  logic                  pend_we;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] pend_wdata;
  logic                  overrun;

  logic   core_req_eff_c;
  logic   grant_c;
  owner_t winner_c;
  logic   spi_grant_c;

  owner_t                owner_q,       owner_d;
  owner_t                last_winner_q, last_winner_d;
  logic                  op_we_q,       op_we_d;
  logic                  mem_en_q,      mem_en_d;
  logic                  mem_we_q,      mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q,   mem_wdata_d;
  logic                  spi_done_q,    spi_done_d;
  logic [DATA_WIDTH-1:0] spi_rdata_q,   spi_rdata_d;
  logic                  core_done_q,   core_done_d;
  logic [DATA_WIDTH-1:0] core_rdata_q,  core_rdata_d;

  spi_req_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_spi_buf (
    .clk        (clk),
    .reset      (reset),
    .spi_req    (bus.spi_req),
    .spi_we     (bus.spi_we),
    .spi_addr   (bus.spi_addr),
    .spi_wdata  (bus.spi_wdata),
    .grant      (spi_grant_c),
    .pend_valid (pend_valid),
    .pend_we    (pend_we),
    .pend_addr  (pend_addr),
    .pend_wdata (pend_wdata),
    .overrun    (overrun)
  );

  // The core still holds its request during the done cycle; mask it to avoid a re-grant.
  assign core_req_eff_c = bus.core_req && !core_done_q;
  assign spi_grant_c    = grant_c && (winner_c == OWN_SPI);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and arbitration
  always_comb begin
    state_d  = state_q;
    grant_c  = 1'b0;
    winner_c = OWN_CORE;
    case (state_q)
      ST_IDLE: begin
        if (pend_valid || core_req_eff_c) begin
          grant_c  = 1'b1;
          winner_c = pick_owner(pend_valid, core_req_eff_c, last_winner_q);
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and slot bookkeeping
  always_comb begin
    owner_d       = owner_q;
    last_winner_d = last_winner_q;
    op_we_d       = op_we_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    spi_done_d    = 1'b0;
    spi_rdata_d   = spi_rdata_q;
    core_done_d   = 1'b0;
    core_rdata_d  = core_rdata_q;

    if (grant_c) begin
      owner_d       = winner_c;
      last_winner_d = winner_c;
      mem_en_d      = 1'b1;
      if (winner_c == OWN_SPI) begin
        op_we_d     = pend_we;
        mem_we_d    = pend_we;
        mem_addr_d  = pend_addr;
        mem_wdata_d = pend_wdata;
      end else begin
        op_we_d     = 1'b0;
        mem_addr_d  = bus.core_addr;
        mem_wdata_d = '0;
      end
    end

    // Read data lands during RESP; capture it and signal completion on the way out.
    if (state_q == ST_RESP) begin
      if (owner_q == OWN_SPI) begin
        spi_done_d = 1'b1;
        if (!op_we_q) begin
          spi_rdata_d = bus.mem_rdata;
        end
      end else begin
        core_done_d  = 1'b1;
        core_rdata_d = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q       <= OWN_CORE;
      last_winner_q <= OWN_CORE;
      op_we_q       <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      spi_done_q    <= 1'b0;
      spi_rdata_q   <= '0;
      core_done_q   <= 1'b0;
      core_rdata_q  <= '0;
    end else begin
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
      op_we_q       <= op_we_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      spi_done_q    <= spi_done_d;
      spi_rdata_q   <= spi_rdata_d;
      core_done_q   <= core_done_d;
      core_rdata_q  <= core_rdata_d;
    end
  end

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.spi_done    = spi_done_q;
  assign bus.spi_rdata   = spi_rdata_q;
  assign bus.spi_overrun = overrun;
  assign bus.core_done   = core_done_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.busy        = (state_q != ST_IDLE) || pend_valid;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Scoreboard bench for memory_access_arbiter: directed stimulus pushes expected
// memory strobes and done pulses; a negedge monitor pops and compares them.
module tb_memory_access_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  memory_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Read-only memory model with one cycle of read latency.
  logic [7:0] rom [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h010] = 8'h3C;
    rom[12'h001] = 8'h11;
    rom[12'h002] = 8'h22;
    for (int i = 0; i < 5; i++) rom[12'h020 + i] = 8'(8'h40 + i);
    for (int i = 0; i < 3; i++) rom[12'h030 + i] = 8'(8'h80 + i);
  end
  always @(posedge clk)
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) bus.mem_rdata <= rom[bus.mem_addr[11:0]];

  typedef struct { int cyc; logic we; logic [15:0] addr; logic [7:0] wdata; } mem_exp_t;
  typedef struct { int cyc; logic chk_data; logic [7:0] data; } done_exp_t;

  mem_exp_t  mem_q[$];
  done_exp_t spi_q[$];
  done_exp_t core_q[$];
  mem_exp_t  m_e;
  done_exp_t d_e;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  task automatic push_mem(input int c, input logic we, input logic [15:0] a, input logic [7:0] d);
    mem_exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wdata = d;
    mem_q.push_back(e);
  endtask

  task automatic push_done(input logic is_spi, input int c, input logic chk_data, input logic [7:0] d);
    done_exp_t e;
    e.cyc = c; e.chk_data = chk_data; e.data = d;
    if (is_spi) spi_q.push_back(e);
    else        core_q.push_back(e);
  endtask

  // Monitor: every strobe and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (mem_q.size() == 0) fail_evt("mem_unexpected", "strobe with no expected access");
      else begin
        m_e = mem_q.pop_front();
        chk("mem_cycle", 32'(cyc), 32'(m_e.cyc));
        chk("mem_we", 32'(bus.mem_we), 32'(m_e.we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(m_e.addr));
        if (m_e.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_e.wdata));
      end
    end
    if (bus.spi_done === 1'b1) begin
      if (spi_q.size() == 0) fail_evt("spi_done_unexpected", "done with no expected completion");
      else begin
        d_e = spi_q.pop_front();
        chk("spi_done_cycle", 32'(cyc), 32'(d_e.cyc));
        if (d_e.chk_data) chk("spi_rdata", 32'(bus.spi_rdata), 32'(d_e.data));
      end
    end
    if (bus.core_done === 1'b1) begin
      if (core_q.size() == 0) fail_evt("core_done_unexpected", "done with no expected completion");
      else begin
        d_e = core_q.pop_front();
        chk("core_done_cycle", 32'(cyc), 32'(d_e.cyc));
        if (d_e.chk_data) chk("core_rdata", 32'(bus.core_rdata), 32'(d_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_pulse(input logic we, input logic [15:0] a, input logic [7:0] d);
    bus.spi_req   = 1'b1;
    bus.spi_we    = we;
    bus.spi_addr  = a;
    bus.spi_wdata = d;
    tick();
    bus.spi_req   = 1'b0;
  endtask

  // Bounded wait for core_done; core drops its request on the edge after seeing it.
  task automatic wait_core_done(input string name);
    int n = 0;
    while (bus.core_done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    if (bus.core_done !== 1'b1) fail_evt(name, "core_done timeout");
    tick();
    bus.core_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_en"},      32'(bus.mem_en),      32'h0);
    chk({tag, "_mem_we"},      32'(bus.mem_we),      32'h0);
    chk({tag, "_mem_addr"},    32'(bus.mem_addr),    32'h0);
    chk({tag, "_mem_wdata"},   32'(bus.mem_wdata),   32'h0);
    chk({tag, "_spi_done"},    32'(bus.spi_done),    32'h0);
    chk({tag, "_spi_rdata"},   32'(bus.spi_rdata),   32'h0);
    chk({tag, "_spi_overrun"}, 32'(bus.spi_overrun), 32'h0);
    chk({tag, "_core_done"},   32'(bus.core_done),   32'h0);
    chk({tag, "_core_rdata"},  32'(bus.core_rdata),  32'h0);
    chk({tag, "_busy"},        32'(bus.busy),        32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int t;
    reset         = 1'b0;
    bus.spi_req   = 1'b0;
    bus.spi_we    = 1'b0;
    bus.spi_addr  = '0;
    bus.spi_wdata = '0;
    bus.core_req  = 1'b0;
    bus.core_addr = '0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // SPI write alone: strobe one edge after capture, done three edges after.
    e = cyc + 1;
    push_mem(e + 1, 1'b1, 16'h0123, 8'hA5);
    push_done(1'b1, e + 3, 1'b0, 8'h00);
    spi_pulse(1'b1, 16'h0123, 8'hA5);
    chk("spi_write_busy", 32'(bus.busy), 32'h1);
    repeat (6) tick();

    // Core read alone.
    e = cyc + 1;
    push_mem(e, 1'b0, 16'h0010, 8'h00);
    push_done(1'b0, e + 2, 1'b1, 8'h3C);
    bus.core_req  = 1'b1;
    bus.core_addr = 16'h0010;
    wait_core_done("core_alone");
    repeat (4) tick();

    // SPI read and core read contending: SPI first (last winner was core), core next slot.
    e = cyc + 1;
    push_mem(e + 1, 1'b0, 16'h0001, 8'h00);
    push_mem(e + 4, 1'b0, 16'h0002, 8'h00);
    push_done(1'b1, e + 3, 1'b1, 8'h11);
    push_done(1'b0, e + 6, 1'b1, 8'h22);
    spi_pulse(1'b0, 16'h0001, 8'h00);
    bus.core_req  = 1'b1;
    bus.core_addr = 16'h0002;
    wait_core_done("contend");
    repeat (4) tick();

    // Overrun: second pulse lands while the first is still pending behind the core.
    e = cyc + 1;
    push_mem(e, 1'b0, 16'h0010, 8'h00);
    push_done(1'b0, e + 2, 1'b1, 8'h3C);
    push_mem(e + 3, 1'b1, 16'h0200, 8'h5A);
    push_done(1'b1, e + 5, 1'b0, 8'h00);
    bus.core_req  = 1'b1;
    bus.core_addr = 16'h0010;
    tick();
    spi_pulse(1'b1, 16'h0200, 8'h5A);
    chk("overrun_first_ok", 32'(bus.spi_overrun), 32'h0);
    spi_pulse(1'b1, 16'h0300, 8'h77);
    chk("overrun_set", 32'(bus.spi_overrun), 32'h1);
    chk("overrun_busy", 32'(bus.busy), 32'h1);
    wait_core_done("overrun_core");
    repeat (6) tick();
    chk("overrun_sticky", 32'(bus.spi_overrun), 32'h1);

    // Reset during ACCESS: everything clears and no done follows.
    e = cyc + 1;
    push_mem(e + 1, 1'b1, 16'h0400, 8'hEE);
    spi_pulse(1'b1, 16'h0400, 8'hEE);
    tick();
    chk("rst_mid_strobe", 32'(bus.mem_en), 32'h1);
    reset = 1'b0;
    tick();
    check_all_zero("rst_mid");
    reset = 1'b1;
    repeat (4) tick();
    e = cyc + 1;
    push_mem(e + 1, 1'b1, 16'h0500, 8'h99);
    push_done(1'b1, e + 3, 1'b0, 8'h00);
    spi_pulse(1'b1, 16'h0500, 8'h99);
    repeat (6) tick();

    // Sustained core reads with an SPI read every 8 cycles.
    t = cyc + 1;
    push_mem(t,      1'b0, 16'h0020, 8'h00);
    push_mem(t + 3,  1'b0, 16'h0030, 8'h00);
    push_mem(t + 6,  1'b0, 16'h0021, 8'h00);
    push_mem(t + 9,  1'b0, 16'h0031, 8'h00);
    push_mem(t + 12, 1'b0, 16'h0022, 8'h00);
    push_mem(t + 16, 1'b0, 16'h0023, 8'h00);
    push_mem(t + 19, 1'b0, 16'h0032, 8'h00);
    push_mem(t + 22, 1'b0, 16'h0024, 8'h00);
    push_done(1'b0, t + 2,  1'b1, 8'h40);
    push_done(1'b0, t + 8,  1'b1, 8'h41);
    push_done(1'b0, t + 14, 1'b1, 8'h42);
    push_done(1'b0, t + 18, 1'b1, 8'h43);
    push_done(1'b0, t + 24, 1'b1, 8'h44);
    push_done(1'b1, t + 5,  1'b1, 8'h80);
    push_done(1'b1, t + 11, 1'b1, 8'h81);
    push_done(1'b1, t + 21, 1'b1, 8'h82);
    fork
      begin
        bus.core_req  = 1'b1;
        bus.core_addr = 16'h0020;
        for (int i = 0; i < 5; i++) begin
          int n = 0;
          while (bus.core_done !== 1'b1 && n < 40) begin
            tick();
            n++;
          end
          if (bus.core_done !== 1'b1) fail_evt("sustained_core", "core_done timeout");
          if (i < 4) bus.core_addr = 16'(16'h0020 + i + 1);
          tick();
        end
        bus.core_req = 1'b0;
      end
      begin
        for (int j = 0; j < 3; j++) begin
          spi_pulse(1'b0, 16'(16'h0030 + j), 8'h00);
          repeat (7) tick();
        end
      end
    join
    repeat (4) tick();
    chk("sustained_no_overrun", 32'(bus.spi_overrun), 32'h0);
    chk("sustained_idle", 32'(bus.busy), 32'h0);

    while (mem_q.size() > 0) begin
      m_e = mem_q.pop_front();
      fail_evt("mem_missing", $sformatf("no strobe for addr 0x%0h at cycle %0d", m_e.addr, m_e.cyc));
    end
    while (spi_q.size() > 0) begin
      d_e = spi_q.pop_front();
      fail_evt("spi_done_missing", $sformatf("no spi_done at cycle %0d", d_e.cyc));
    end
    while (core_q.size() > 0) begin
      d_e = core_q.pop_front();
      fail_evt("core_done_missing", $sformatf("no core_done at cycle %0d", d_e.cyc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
